num_alu_pipe: RTL
=================

// Module: num_alu_pipe
// PURPOSE
//  Parametrised, pipelined two-operand integer unit: plus, minus and mul with a
//  runtime op select. Supports configurable width and signedness.
//  Wraps results two's-complement modulo 2^WIDTH and reports overflow.
//  Valid/ready on input and output lets it sit inline in streaming datapaths in
//  place of the fixed-width combinational plus/minus/mul blocks.
// PARAMETERS
//  WIDTH       64  operand/result width in bits (>=2); 8 and 64 match byte/longint
//  SIGNED      1   1: operands/result signed two's complement; 0: unsigned
//  MUL_STAGES  2   register stages in the multiply path (>=1); sets total latency
// PORTS
//  i_clk       in   1      clock, all state on rising edge
//  i_rst       in   1      synchronous, active-high reset
//  i_valid     in   1      input operands/op valid
//  o_ready     out  1      unit accepts input this cycle
//  i_op        in   2      00 plus, 01 minus, 10 mul, 11 reserved (treated as plus)
//  i_a         in   WIDTH  operand A
//  i_b         in   WIDTH  operand B
//  o_valid     out  1      result valid
//  i_ready     in   1      downstream accepts result
//  o_res       out  WIDTH  result (low WIDTH bits, or saturated if enabled)
//  o_ovf       out  1      true result not representable in WIDTH bits
// BEHAVIOUR
//  - Reset: o_valid=0, o_res=0, o_ovf=0, all internal stage valids=0; o_ready=1
//    the cycle after reset deasserts.
//  - Fixed latency LAT=MUL_STAGES+1 for every op: an op accepted in cycle t
//    yields o_valid in cycle t+LAT, absent stalls. Plus/minus are delay-matched
//    through the mul stages; results leave strictly in acceptance order.
//  - Stall: adv = !o_valid || i_ready; o_ready = adv. When adv=0 every stage
//    holds, including data, op, and ovf. Transfer occurs on i_valid&&o_ready at input,
//    o_valid&&i_ready at output. Simultaneous accept and drain sustain 1 op/cycle.
//  - o_res/o_ovf stable while o_valid=1 and i_ready=0.
//  - Arithmetic: internal result computed at full precision: WIDTH+1 for
//    plus/minus, 2*WIDTH for mul, sign-extended per SIGNED.
//    o_res = low WIDTH bits.
//  - o_ovf: SIGNED=1, full result outside [-2^(W-1), 2^(W-1)-1];
//    SIGNED=0, plus carry-out, minus borrow (a<b), or mul high half nonzero.
//  - i_op=11: computed as plus; o_ovf reflects plus.
//  - Bubbles, i.e. stages with valid=0, collapse only via the adv rule; the
//    pipeline does not compact around bubbles.
//  - i_rst mid-operation: all in-flight ops discarded, no output for them;
//    inputs presented in the reset cycle are not accepted.
// CONFIGURATION
//  NUM_ALU_SAT_EN defined: on overflow o_res clamps to the max/min
//    representable value in the direction of the true result. SIGNED=1 uses
//    2^(W-1)-1 or -2^(W-1). SIGNED=0 uses 2^W-1, or 0 for minus borrow.
//    o_ovf still asserts. Latency unchanged.
//  NUM_ALU_SAT_EN undefined: o_res is always the wrapped low WIDTH bits;
//    no clamp logic is instantiated.
// TESTING (WIDTH=8, MUL_STAGES=2 unless noted)
//  1 SIGNED=0, plus 200+100, i_ready=1 -> o_res=44, o_ovf=1 exactly 3 cycles later;
//    with NUM_ALU_SAT_EN -> o_res=255, o_ovf=1.
//  2 SIGNED=1, minus -128-1 -> o_res=127 (0x7F), o_ovf=1; with NUM_ALU_SAT_EN
//    -> o_res=-128 (0x80). Then minus 5-7 -> o_res=-2 (0xFE), o_ovf=0.
//  3 SIGNED=1, mul -3*5 -> 0xF1, o_ovf=0. SIGNED=0, mul 16*16 -> 0, o_ovf=1.
//    mul 15*17 -> 255, o_ovf=0.
//  4 Back-to-back stream of plus, mul, and minus ops, one per cycle, with
//    i_ready=1 -> results in input order, one per cycle, each at LAT=3.
//  5 i_ready held 0 for 5 cycles mid-stream -> o_ready=0 while o_valid=1.
//    Output stays stable; no op lost or duplicated after release.
//  6 i_rst pulsed for 1 cycle with 2 ops in flight -> o_valid=0 next cycle,
//    those ops never emerge; new op after reset returns at LAT.
//    WIDTH=64 SIGNED=1 smoke run: 2^62*2 -> o_res=-2^63, o_ovf=1.

Source files
------------

// File: rtl/num_alu_pipe.sv
// Pipelined plus/minus/mul unit with valid/ready handshakes and fixed latency MUL_STAGES+1.
// Optional result clamping on overflow when NUM_ALU_SAT_EN is defined.
module num_alu_pipe #(
  parameter int WIDTH      = 64,
  parameter bit SIGNED     = 1'b1,
  parameter int MUL_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_res,
  output logic             o_ovf
);
  localparam int W   = WIDTH;
  localparam int LAT = MUL_STAGES + 1;

  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_RSV = 2'b11} op_e;
  typedef struct packed {
    op_e          op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } req_t;
  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
  } rsp_t;

  logic                  adv, acc;
  logic [LAT:1]          vld_pipe;
  req_t                  req_q;
  rsp_t                  rsp_d;
  rsp_t [MUL_STAGES:1]   rsp_pipe;
  logic                  sa, sb;
  logic [W:0]            sum, dif;
  logic [2*W-1:0]        prod;

  // Whole pipe moves as one; bubbles only disappear when the output side drains.
  assign adv     = !o_valid || i_ready;
  assign o_ready = adv;
  assign acc     = i_valid && adv;
  assign o_valid = vld_pipe[LAT];
  assign o_res   = rsp_pipe[MUL_STAGES].res;
  assign o_ovf   = rsp_pipe[MUL_STAGES].ovf;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe <= '0;
      req_q    <= '0;
      rsp_pipe <= '0;
    end else if (adv) begin
      vld_pipe    <= {vld_pipe[LAT-1:1], acc};
      req_q       <= '{op: op_e'(i_op), a: i_a, b: i_b};
      rsp_pipe[1] <= rsp_d;
      for (int k = 2; k <= MUL_STAGES; k++) rsp_pipe[k] <= rsp_pipe[k-1];
    end
  end

  // Extended-precision operands: one extra bit for plus/minus, double width for mul.
  assign sa   = SIGNED & req_q.a[W-1];
  assign sb   = SIGNED & req_q.b[W-1];
  assign sum  = {sa, req_q.a} + {sb, req_q.b};
  assign dif  = {sa, req_q.a} - {sb, req_q.b};
  assign prod = {{W{sa}}, req_q.a} * {{W{sb}}, req_q.b};

`ifdef NUM_ALU_SAT_EN
  logic neg;
`endif

  always_comb begin
    rsp_d = '0;
    case (req_q.op)
      OP_SUB: begin
        rsp_d.res = dif[W-1:0];
        rsp_d.ovf = SIGNED ? (dif[W] ^ dif[W-1]) : dif[W];
      end
      OP_MUL: begin
        rsp_d.res = prod[W-1:0];
        rsp_d.ovf = SIGNED ? !((&prod[2*W-1:W-1]) || !(|prod[2*W-1:W-1]))
                           : (|prod[2*W-1:W]);
      end
      default: begin
        rsp_d.res = sum[W-1:0];
        rsp_d.ovf = SIGNED ? (sum[W] ^ sum[W-1]) : sum[W];
      end
    endcase
`ifdef NUM_ALU_SAT_EN
    // Top bit of the extended result is the true sign; it picks the clamp direction.
    neg = (req_q.op == OP_MUL) ? prod[2*W-1] : (req_q.op == OP_SUB) ? dif[W] : sum[W];
    if (rsp_d.ovf) begin
      if (SIGNED) rsp_d.res = neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else        rsp_d.res = (req_q.op == OP_SUB) ? '0 : '1;
    end
`endif
  end
endmodule
